// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line, enable and received-frame outputs for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                    uart_rxd;
  logic                    uart_rx_en;
  logic                    uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_rx_frame_err;
  logic                    uart_rx_break;

  modport master (
    output uart_rxd,
    output uart_rx_en,
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_frame_err,
    input  uart_rx_break
  );

  modport slave (
    input  uart_rxd,
    input  uart_rx_en,
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_frame_err,
    output uart_rx_break
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : Mid-bit sampling UART receiver with frame-error and break pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
  localparam int BIT_CNT_W      = 1 + $clog2(PAYLOAD_BITS);

  localparam logic [CNT_W-1:0]     C_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0]     C_BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] C_LAST_BIT  = BIT_CNT_W'(PAYLOAD_BITS - 1);

  if (STOP_BITS < 1) begin : g_bad_stop_bits
    $error("uart_rx: STOP_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    rxd_meta_q, rxd_meta_d;
  logic                    rxd_s_q, rxd_s_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    break_q, break_d;
  logic                    rearm_lock_q, rearm_lock_d;
  logic [PAYLOAD_BITS:0]   shift_in;

  // Line order is LSB first, so each new sample enters at the top.
  assign shift_in = {rxd_s_q, shift_q};

  always_comb begin
    rxd_meta_d   = rx.uart_rxd;
    rxd_s_d      = rxd_meta_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    break_d      = 1'b0;
    rearm_lock_d = rearm_lock_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxd_s_q) begin
          rearm_lock_d = 1'b0;
        end
        if (!rxd_s_q && rx.uart_rx_en && !rearm_lock_q) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d   = RECV;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RECV: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = shift_in[PAYLOAD_BITS:1];
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == C_LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        // Re-arm at mid-stop-bit so back-to-back frames are not missed.
        if (cnt_q == C_BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
            break_d      = (shift_q == '0);
            rearm_lock_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      rearm_lock_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_s_q      <= rxd_s_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      rearm_lock_q <= rearm_lock_d;
    end
  end

  assign rx.uart_rx_valid     = valid_q;
  assign rx.uart_rx_data      = data_q;
  assign rx.uart_rx_frame_err = frame_err_q;
  assign rx.uart_rx_break     = break_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed frame stimulus for uart_rx with pulse counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 434;

  logic clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  int valid_cnt = 0;
  int err_cnt   = 0;
  int brk_cnt   = 0;
  int overlap   = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  int v0, e0, b0;

  uart_rx_if #(.PAYLOAD_BITS(8)) rx_if ();

  uart_rx #(
    .BIT_RATE    (115200),
    .CLK_HZ      (50_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_if.uart_rx_valid) begin
      valid_cnt = valid_cnt + 1;
      prev_data = last_data;
      last_data = rx_if.uart_rx_data;
    end
    if (rx_if.uart_rx_frame_err) err_cnt = err_cnt + 1;
    if (rx_if.uart_rx_break)     brk_cnt = brk_cnt + 1;
    if (rx_if.uart_rx_valid && (rx_if.uart_rx_frame_err || rx_if.uart_rx_break))
      overlap = overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_if.uart_rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  // rst_bit selects a data bit during which reset is pulsed (-1 for none).
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int rst_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        rx_if.uart_rxd = b[i];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (CPB - CPB / 2 - 3) @(negedge clk);
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(stop_val);
  endtask

  task automatic idle_bits(input int n);
    rx_if.uart_rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
    b0 = brk_cnt;
  endtask

  initial begin
    reset            = 1'b1;
    rx_if.uart_rxd   = 1'b1;
    rx_if.uart_rx_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid", {31'd0, rx_if.uart_rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_if.uart_rx_data}, 32'd0);
    check("rst_ferr", {31'd0, rx_if.uart_rx_frame_err}, 32'd0);
    check("rst_break", {31'd0, rx_if.uart_rx_break}, 32'd0);
    reset = 1'b0;
    idle_bits(1);

    // Single good frame
    snap();
    send_frame(8'h55, 1'b1, -1);
    idle_bits(2);
    check("f55_valid_cnt", valid_cnt - v0, 1);
    check("f55_data", {24'd0, last_data}, 32'h55);
    check("f55_ferr_cnt", err_cnt - e0, 0);
    check("f55_break_cnt", brk_cnt - b0, 0);

    // Back-to-back frames, no inter-frame gap
    snap();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle_bits(2);
    check("b2b_valid_cnt", valid_cnt - v0, 2);
    check("b2b_first", {24'd0, prev_data}, 32'h00);
    check("b2b_second", {24'd0, last_data}, 32'hFF);
    check("b2b_ferr_cnt", err_cnt - e0, 0);

    // Short low glitch
    snap();
    rx_if.uart_rxd = 1'b0;
    repeat (100) @(negedge clk);
    idle_bits(2);
    check("glitch_valid_cnt", valid_cnt - v0, 0);
    check("glitch_ferr_cnt", err_cnt - e0, 0);
    check("glitch_break_cnt", brk_cnt - b0, 0);

    // Bad stop bit on a non-zero payload
    snap();
    send_frame(8'hA3, 1'b0, -1);
    idle_bits(2);
    check("ferr_ferr_cnt", err_cnt - e0, 1);
    check("ferr_break_cnt", brk_cnt - b0, 0);
    check("ferr_valid_cnt", valid_cnt - v0, 0);
    check("ferr_data_held", {24'd0, rx_if.uart_rx_data}, 32'hFF);

    // Line held low for 20 bit periods, then a good frame
    snap();
    rx_if.uart_rxd = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    idle_bits(2);
    send_frame(8'h3C, 1'b1, -1);
    idle_bits(2);
    check("brk_ferr_cnt", err_cnt - e0, 1);
    check("brk_break_cnt", brk_cnt - b0, 1);
    check("brk_valid_cnt", valid_cnt - v0, 1);
    check("brk_next_data", {24'd0, last_data}, 32'h3C);

    // Reset in data bit 4 abandons the frame
    snap();
    send_frame(8'hF0, 1'b1, 4);
    idle_bits(1);
    send_frame(8'h81, 1'b1, -1);
    idle_bits(2);
    check("rst_mid_valid_cnt", valid_cnt - v0, 1);
    check("rst_mid_data", {24'd0, rx_if.uart_rx_data}, 32'h81);
    check("rst_mid_ferr_cnt", err_cnt - e0, 0);

    // Receiver disabled
    snap();
    rx_if.uart_rx_en = 1'b0;
    send_frame(8'h12, 1'b1, -1);
    idle_bits(2);
    rx_if.uart_rx_en = 1'b1;
    check("dis_valid_cnt", valid_cnt - v0, 0);
    check("dis_ferr_cnt", err_cnt - e0, 0);
    check("dis_break_cnt", brk_cnt - b0, 0);
    check("dis_data_held", {24'd0, rx_if.uart_rx_data}, 32'h81);

    check("valid_err_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_RATE, default 115200, line bit rate in bits/s.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; only the first stop bit is checked.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port uart_rx_en, input, 1, receive enable; when low, new frames are not started.
REQ-009 SHALL have port uart_rx_valid, output, 1, one-cycle pulse when uart_rx_data holds a new good frame.
REQ-010 SHALL have port uart_rx_data, output, PAYLOAD_BITS, last received payload.
REQ-011 SHALL have port uart_rx_frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port uart_rx_break, output, 1, one-cycle pulse on a break (all-zero payload and bad stop bit).

Function
REQ-013 CYCLES_PER_BIT SHALL be CLK_HZ/BIT_RATE, using integer division; the defaults give 434.
REQ-014 HALF_BIT SHALL be CYCLES_PER_BIT/2, using integer division; the default gives 217.
REQ-015 The cycle counter width SHALL be 1+clog2(CYCLES_PER_BIT) bits.
REQ-016 uart_rxd SHALL pass through a 2-flop synchronizer to give rxd_s; all decisions use rxd_s only.
REQ-017 The FSM SHALL have states IDLE, START, RECV and STOP.
REQ-018 IDLE SHALL go to START when rxd_s==0 and uart_rx_en==1; the cycle counter is cleared on entry.
REQ-019 START SHALL sample rxd_s when counter==HALF_BIT-1.
- Sample 0: go to RECV, clear the counter and the bit counter.
- Sample 1: treat as a glitch and return to IDLE with no output pulse.
REQ-020 RECV SHALL sample rxd_s when counter==CYCLES_PER_BIT-1, then clear the counter.
- Shift the sample into the MSB of the shift register (LSB-first line order) and increment the bit counter.
- After PAYLOAD_BITS samples, go to STOP.
REQ-021 STOP SHALL sample rxd_s when counter==CYCLES_PER_BIT-1, then return to IDLE.
- It SHALL NOT wait out the remaining stop-bit time, so the receiver re-arms at mid-stop-bit.
REQ-022 If the stop sample is 1, the cycle after it SHALL load uart_rx_data from the shift register and pulse uart_rx_valid.
REQ-023 If the stop sample is 0, the cycle after it SHALL pulse uart_rx_frame_err.
- uart_rx_valid stays 0 and uart_rx_data is unchanged.
- If the shift register is all zero, uart_rx_break also pulses in the same cycle.
REQ-024 After a frame error, IDLE SHALL NOT re-arm until rxd_s has been seen high for at least one cycle, so a held-low line yields exactly one error/break.
REQ-025 uart_rx_en going low mid-frame SHALL NOT abort that frame; it only blocks IDLE->START.
REQ-026 uart_rx_valid, uart_rx_frame_err and uart_rx_break SHALL each be high for exactly one cycle per event, and never high together except frame_err with break.
REQ-027 uart_rx_data SHALL hold its value until the next valid pulse.
REQ-028 There SHALL be no output back-pressure; a missed pulse is lost.

Reset
REQ-029 On reset==1 at a rising clk edge:
- FSM goes to IDLE; counters and shift register are cleared.
- Synchronizer flops are set to 1.
- uart_rx_valid, uart_rx_frame_err and uart_rx_break are 0; uart_rx_data is 0.
- The break re-arm lock of REQ-024 is cleared.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no pulse.
- After release, a line still low SHALL be treated as a new start edge if uart_rx_en==1.

Verification
REQ-031 Frame 0x55 at 434 cycles/bit -> one uart_rx_valid pulse, uart_rx_data==0x55, uart_rx_frame_err==0.
REQ-032 Back-to-back frames 0x00 then 0xFF with 1 stop bit and no gap -> two valid pulses with data 0x00 then 0xFF and no errors.
REQ-033 uart_rxd low for 100 cycles then high -> no pulse on any output; FSM back in IDLE.
REQ-034 Frame 0xA3 with stop bit driven 0 -> uart_rx_frame_err pulse, uart_rx_break==0, no valid pulse, uart_rx_data keeps its previous value.
REQ-035 uart_rxd held low for 20 bit periods -> exactly one frame_err+break pulse; the next good frame 0x3C is received correctly after the line returns high.
REQ-036 Reset pulsed during data bit 4, then frame 0x81 -> no pulse for the aborted frame; 0x81 received with one valid pulse.
REQ-037 uart_rx_en==0 while frame 0x12 is sent -> no pulse on any output.
